// File: rtl/instr_fetch_unit.sv
// Program counter and instruction-fetch stage with a loadable instruction memory.
// Sequential or relative next-PC selection, halt on jump-to-self, and a retire counter.
module instr_fetch_unit #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic [PC_W-1:0]    load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               run,
    input  logic               pc_override,
    input  logic [PC_W-1:0]    pc_val,
    output logic [INSTR_W-1:0] instruction,
    output logic [PC_W-1:0]    pc,
    output logic               instr_valid,
    output logic               halted,
    output logic [CNT_W-1:0]   instr_count
);

    typedef enum logic [2:0] {IDLE, PRIME, RUN, PAUSE, HALT} state_t;

    state_t             state, state_nx;
    logic [INSTR_W-1:0] mem [2**PC_W];

    logic [PC_W-1:0]    next_pc, pc_nx;
    logic [INSTR_W-1:0] instr_nx;
    logic [CNT_W-1:0]   cnt_nx;
    logic               valid_nx, halted_nx;
    logic               jump_self;

    assign jump_self = !pc_override && (pc_val == '0);
    assign next_pc   = pc_override ? pc + PC_W'(1) : pc + pc_val;

    // Memory survives reset; writes are accepted only while idle.
    always_ff @(posedge clk) begin
        if (!rst && state == IDLE && load_en)
            mem[load_addr] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (run) state_nx = PRIME;
            PRIME: state_nx = RUN;
            RUN: begin
                if (!run)
                    state_nx = PAUSE;
                else if (jump_self)
                    state_nx = HALT;
            end
            PAUSE: if (run) state_nx = RUN;
            HALT:  if (!run) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        pc_nx     = pc;
        instr_nx  = instruction;
        cnt_nx    = instr_count;
        valid_nx  = instr_valid;
        halted_nx = halted;
        unique case (state)
            IDLE: begin
                if (run) begin
                    pc_nx  = '0;
                    cnt_nx = '0;
                end
            end
            PRIME: begin
                instr_nx = mem[pc];
                valid_nx = 1'b1;
            end
            RUN: begin
                if (!run) begin
                    valid_nx = 1'b0;
                end else begin
                    pc_nx    = next_pc;
                    instr_nx = mem[next_pc];
                    if (instr_count != '1)
                        cnt_nx = instr_count + CNT_W'(1);
                    if (jump_self) begin
                        valid_nx  = 1'b0;
                        halted_nx = 1'b1;
                    end
                end
            end
            // Resume needs no refetch: instruction still holds mem[pc].
            PAUSE: if (run) valid_nx = 1'b1;
            HALT:  if (!run) halted_nx = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= '0;
            instruction <= '0;
            instr_count <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            pc          <= pc_nx;
            instruction <= instr_nx;
            instr_count <= cnt_nx;
            instr_valid <= valid_nx;
            halted      <= halted_nx;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus queues expected fetches, a monitor
// checks every valid cycle; a small control-unit stub decodes 2'b11 prefixes as jumps.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, load_en, run;
    logic [7:0]  load_addr, load_data;
    logic        pc_override;
    logic [7:0]  pc_val;
    logic [7:0]  instruction, pc;
    logic        instr_valid, halted;
    logic [15:0] instr_count;

    typedef struct {
        logic [7:0]  pc;
        logic [7:0]  ins;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.PC_W(8), .INSTR_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .run(run), .pc_override(pc_override),
        .pc_val(pc_val), .instruction(instruction), .pc(pc),
        .instr_valid(instr_valid), .halted(halted), .instr_count(instr_count)
    );

    // Control-unit stub: 11xxxxxx = jump by sign-extended 6-bit offset, else sequential.
    assign pc_override = (instruction[7:6] != 2'b11);
    assign pc_val      = {{2{instruction[5]}}, instruction[5:0]};

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] p, input logic [7:0] i, input logic [15:0] c);
        exp_t e;
        e.pc = p; e.ins = i; e.cnt = c;
        q.push_back(e);
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick(1);
        load_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0;
        tick(1);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (instr_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("mon_pc", int'(pc), int'(e.pc));
                chk("mon_instr", int'(instruction), int'(e.ins));
                chk("mon_count", int'(instr_count), int'(e.cnt));
            end
        end
    end

    initial begin
        rst = 1'b1; run = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        tick(2);
        chk("rst_pc", int'(pc), 0);
        chk("rst_instr", int'(instruction), 0);
        chk("rst_valid", int'(instr_valid), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_count", int'(instr_count), 0);
        rst = 1'b0;

        // Straight-line program ending in jump-to-self at pc 3.
        load(8'd0, 8'h01); load(8'd1, 8'h82); load(8'd2, 8'h03); load(8'd3, 8'hC0);
        push(8'd0, 8'h01, 16'd0); push(8'd1, 8'h82, 16'd1);
        push(8'd2, 8'h03, 16'd2); push(8'd3, 8'hC0, 16'd3);
        run = 1'b1;
        tick(1);
        chk("prime_valid", int'(instr_valid), 0);
        tick(1);
        chk("first_valid", int'(instr_valid), 1);
        tick(3);
        chk("pre_halt", int'(halted), 0);
        tick(1);
        chk("halt_flag", int'(halted), 1);
        chk("halt_valid", int'(instr_valid), 0);
        chk("halt_pc", int'(pc), 3);
        chk("halt_instr", int'(instruction), 8'hC0);
        chk("halt_count", int'(instr_count), 4);
        tick(2);
        chk("halt_hold_pc", int'(pc), 3);
        chk("halt_hold_count", int'(instr_count), 4);
        run = 1'b0;
        tick(1);
        chk("halt_exit", int'(halted), 0);

        // Backward jump loop, paused at pc 2, resumed, load attempt, reset mid-run.
        load(8'd0, 8'h01); load(8'd1, 8'h02); load(8'd2, 8'hFE);
        push(8'd0, 8'h01, 16'd0); push(8'd1, 8'h02, 16'd1); push(8'd2, 8'hFE, 16'd2);
        push(8'd0, 8'h01, 16'd3); push(8'd1, 8'h02, 16'd4); push(8'd2, 8'hFE, 16'd5);
        run = 1'b1;
        tick(7);
        run = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("pause_valid", int'(instr_valid), 0);
            chk("pause_pc", int'(pc), 2);
            chk("pause_instr", int'(instruction), 8'hFE);
            chk("pause_count", int'(instr_count), 5);
        end
        push(8'd2, 8'hFE, 16'd5); push(8'd0, 8'h01, 16'd6); push(8'd1, 8'h02, 16'd7);
        run = 1'b1;
        tick(1);
        load_en = 1'b1; load_addr = 8'd0; load_data = 8'hAA;
        tick(1);
        load_en = 1'b0;
        tick(1);
        rst = 1'b1; run = 1'b0;
        tick(1);
        chk("midrst_pc", int'(pc), 0);
        chk("midrst_valid", int'(instr_valid), 0);
        chk("midrst_count", int'(instr_count), 0);
        rst = 1'b0;
        push(8'd0, 8'h01, 16'd0); push(8'd1, 8'h02, 16'd1);
        run = 1'b1;
        tick(3);
        do_reset();

        // Wrap-around: 1 -> 255 by offset -2, then 255 -> 0 sequentially.
        load(8'd0, 8'h01); load(8'd1, 8'hFE); load(8'd255, 8'h05);
        push(8'd0, 8'h01, 16'd0); push(8'd1, 8'hFE, 16'd1); push(8'd255, 8'h05, 16'd2);
        push(8'd0, 8'h01, 16'd3); push(8'd1, 8'hFE, 16'd4);
        run = 1'b1;
        tick(6);
        do_reset();
        load(8'd0, 8'hC0);
        push(8'd0, 8'hC0, 16'd0);
        run = 1'b1;
        tick(3);
        chk("halt0_flag", int'(halted), 1);
        chk("halt0_pc", int'(pc), 0);
        chk("halt0_count", int'(instr_count), 1);
        run = 1'b0;
        tick(1);

        // Saturation: 0x01 / 0xFF two-instruction loop past 65535 retirements.
        load(8'd0, 8'h01); load(8'd1, 8'hFF);
        for (int k = 0; k < 65540; k++)
            push((k % 2 == 1) ? 8'd1 : 8'd0, (k % 2 == 1) ? 8'hFF : 8'h01,
                 (k < 65535) ? 16'(k) : 16'hFFFF);
        run = 1'b1;
        tick(65541);
        run = 1'b0;
        tick(1);
        chk("sat_count", int'(instr_count), 16'hFFFF);
        chk("sat_valid", int'(instr_valid), 0);
        tick(1);
        chk("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
